// File: rtl/mips_boot_trace.sv
// mips_boot_trace: streams a program image into instruction memory, holds the
// core in reset for a programmable settle time, then releases it and records
// every new (PC, IR) pair into a first-word-fall-through trace FIFO with
// saturating accounting of samples lost to a full FIFO.
module mips_boot_trace #(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int RST_HOLD    = 2,
    parameter int TRACE_DEPTH = 16,
    parameter int DROP_W      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_ld_valid,
    output logic                             o_ld_ready,
    input  logic [DW-1:0]                    i_ld_data,
    input  logic                             i_ld_last,
    output logic                             o_im_we,
    output logic [AW-1:0]                    o_im_addr,
    output logic [DW-1:0]                    o_im_wdata,
    output logic                             o_cpu_rst,
    input  logic [DW-1:0]                    i_cpu_pc,
    input  logic [DW-1:0]                    i_cpu_instr,
    output logic                             o_tr_valid,
    input  logic                             i_tr_ready,
    output logic [DW-1:0]                    o_tr_pc,
    output logic [DW-1:0]                    o_tr_instr,
    output logic [$clog2(TRACE_DEPTH+1)-1:0] o_tr_count,
    output logic [DROP_W-1:0]                o_drop_cnt,
    output logic                             o_load_err,
    output logic                             o_busy
);

    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = $clog2(TRACE_DEPTH + 1);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [AW-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_ld_ready;
    logic            w_busy;
    logic            w_hs;
    logic            w_last_word;

    logic [AW-1:0]   r_load_addr;
    logic            r_im_we;
    logic [AW-1:0]   r_im_addr;
    logic [DW-1:0]   r_im_wdata;
    logic            r_load_err;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_cpu_rst;

    logic            r_have_pc;
    logic [DW-1:0]   r_last_pc;
    logic [DW-1:0]   r_mem_pc    [TRACE_DEPTH];
    logic [DW-1:0]   r_mem_instr [TRACE_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [DROP_W-1:0] r_drop_cnt;

    logic            w_sample;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Phase register: LOAD -> HOLD -> RUN, RUN is left only through reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next phase plus the phase-derived handshake and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_ld_ready   = 1'b0;
        w_busy       = 1'b1;
        w_hs         = 1'b0;
        w_last_word  = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_ld_ready  = 1'b1;
                w_hs        = i_ld_valid;
                // The top word ends the load even without ld_last, so no
                // address is ever written twice.
                w_last_word = i_ld_last || (r_load_addr == ADDR_MAX);
                if (w_hs && w_last_word) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b0;
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    assign o_ld_ready = w_ld_ready;
    assign o_busy     = w_busy;

    // Registered instruction-memory write port driven by loader handshakes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_load_addr <= '0;
            r_im_we     <= 1'b0;
            r_im_addr   <= '0;
            r_im_wdata  <= '0;
            r_load_err  <= 1'b0;
        end else begin
            r_im_we <= w_hs;
            if (w_hs) begin
                r_im_addr   <= r_load_addr;
                r_im_wdata  <= i_ld_data;
                r_load_addr <= r_load_addr + AW'(1);
                if (!i_ld_last && (r_load_addr == ADDR_MAX)) begin
                    r_load_err <= 1'b1;
                end
            end
        end
    end

    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_load_err = r_load_err;

    // Settle counter preset throughout LOAD so it is ready on HOLD entry;
    // core reset drops on the same edge that enters RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt <= '0;
            r_cpu_rst  <= 1'b1;
        end else begin
            if (r_state == S_LOAD) begin
                r_hold_cnt <= HW'(RST_HOLD - 1);
            end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - HW'(1);
            end
            r_cpu_rst <= (w_state_next != S_RUN);
        end
    end

    assign o_cpu_rst = r_cpu_rst;

    // A sample is due on the first RUN cycle and whenever the PC moves.
    assign w_sample = (r_state == S_RUN) && (!r_have_pc || (i_cpu_pc != r_last_pc));
    assign w_full   = (r_count == CW'(TRACE_DEPTH));
    assign w_pop    = o_tr_valid && i_tr_ready;
    assign w_push   = w_sample && (!w_full || w_pop);
    assign w_drop   = w_sample && w_full && !w_pop;

    // Remember the last sampled PC, whether or not the sample fitted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_have_pc <= 1'b0;
            r_last_pc <= '0;
        end else if (w_sample) begin
            r_have_pc <= 1'b1;
            r_last_pc <= i_cpu_pc;
        end
    end

    // Trace storage; contents need no reset because empty slots are masked.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= i_cpu_pc;
            r_mem_instr[r_wr_ptr] <= i_cpu_instr;
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign o_tr_valid = (r_count != '0);
    assign o_tr_pc    = o_tr_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign o_tr_instr = o_tr_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign o_tr_count = r_count;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_mips_boot_trace.sv
// Bench for mips_boot_trace: two instances (default sizing, and a small one
// with a 4-word memory, 4-entry FIFO and 3-bit drop counter) driven by
// directed steps with random data, checked against a queue-based model.
module tb_mips_boot_trace;

    localparam int A_AW = 10, A_HOLD = 2, A_DEPTH = 16, A_DROPW = 16;
    localparam int B_AW = 2,  B_HOLD = 3, B_DEPTH = 4,  B_DROPW = 3;

    logic        clk;
    logic        rst       [2];
    logic        ld_valid  [2];
    logic [31:0] ld_data   [2];
    logic        ld_last   [2];
    logic [31:0] cpu_pc    [2];
    logic [31:0] cpu_instr [2];
    logic        tr_ready  [2];

    wire         ready_o   [2];
    wire         we_o      [2];
    wire  [9:0]  addr_o    [2];
    wire  [31:0] wdata_o   [2];
    wire         cpurst_o  [2];
    wire         valid_o   [2];
    wire  [31:0] trpc_o    [2];
    wire  [31:0] trinstr_o [2];
    wire  [4:0]  cnt_o     [2];
    wire  [15:0] drop_o    [2];
    wire         err_o     [2];
    wire         busy_o    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int AW    = (gi == 0) ? A_AW    : B_AW;
        localparam int HOLD  = (gi == 0) ? A_HOLD  : B_HOLD;
        localparam int DEPTH = (gi == 0) ? A_DEPTH : B_DEPTH;
        localparam int DRW   = (gi == 0) ? A_DROPW : B_DROPW;
        wire [AW-1:0]                  im_addr;
        wire [$clog2(DEPTH+1)-1:0]     tr_count;
        wire [DRW-1:0]                 drop_cnt;
        mips_boot_trace #(
            .AW(AW), .DW(32), .RST_HOLD(HOLD), .TRACE_DEPTH(DEPTH), .DROP_W(DRW)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst[gi]),
            .i_ld_valid  (ld_valid[gi]),
            .o_ld_ready  (ready_o[gi]),
            .i_ld_data   (ld_data[gi]),
            .i_ld_last   (ld_last[gi]),
            .o_im_we     (we_o[gi]),
            .o_im_addr   (im_addr),
            .o_im_wdata  (wdata_o[gi]),
            .o_cpu_rst   (cpurst_o[gi]),
            .i_cpu_pc    (cpu_pc[gi]),
            .i_cpu_instr (cpu_instr[gi]),
            .o_tr_valid  (valid_o[gi]),
            .i_tr_ready  (tr_ready[gi]),
            .o_tr_pc     (trpc_o[gi]),
            .o_tr_instr  (trinstr_o[gi]),
            .o_tr_count  (tr_count),
            .o_drop_cnt  (drop_cnt),
            .o_load_err  (err_o[gi]),
            .o_busy      (busy_o[gi])
        );
        assign addr_o[gi] = 10'(im_addr);
        assign cnt_o[gi]  = 5'(tr_count);
        assign drop_o[gi] = 16'(drop_cnt);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // loader / sequencer model per instance
    int next_addr  [2];
    int since_done [2];
    bit done       [2];
    bit err        [2];

    // trace model for the instance currently under test
    logic [63:0] q[$];
    int          mdrop;
    bit          have;
    logic [31:0] last_pc;
    int          dut_pops;

    function automatic int hold_of(input int s);  return (s == 0) ? A_HOLD : B_HOLD; endfunction
    function automatic int words_of(input int s); return (s == 0) ? (1 << A_AW) : (1 << B_AW); endfunction
    function automatic int depth_of(input int s); return (s == 0) ? A_DEPTH : B_DEPTH; endfunction
    function automatic int dmax_of(input int s);  return (s == 0) ? ((1 << A_DROPW) - 1) : ((1 << B_DROPW) - 1); endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int s = 0; s < 2; s++) if (done[s]) since_done[s]++;
        #1;
    endtask

    task automatic model_reset(input int s);
        next_addr[s] = 0; since_done[s] = 0; done[s] = 0; err[s] = 0;
    endtask

    task automatic check_core(input int s);
        bit held;
        held = !(done[s] && (since_done[s] > hold_of(s)));
        chk("cpu_rst", cpurst_o[s], held);
        chk("busy", busy_o[s], held);
        chk("ld_ready", ready_o[s], !done[s]);
    endtask

    task automatic check_reset_state(input int s);
        chk("rst_ld_ready", ready_o[s], 1);
        chk("rst_im_we", we_o[s], 0);
        chk("rst_im_addr", addr_o[s], 0);
        chk("rst_im_wdata", wdata_o[s], 0);
        chk("rst_cpu_rst", cpurst_o[s], 1);
        chk("rst_tr_valid", valid_o[s], 0);
        chk("rst_tr_count", cnt_o[s], 0);
        chk("rst_tr_pc", trpc_o[s], 0);
        chk("rst_tr_instr", trinstr_o[s], 0);
        chk("rst_drop_cnt", drop_o[s], 0);
        chk("rst_load_err", err_o[s], 0);
        chk("rst_busy", busy_o[s], 1);
    endtask

    task automatic load_word(input int s, input logic [31:0] w, input logic last, input int gap);
        bit acc;
        int a;
        ld_valid[s] = 1'b1; ld_data[s] = w; ld_last[s] = last;
        acc = !done[s];
        a   = next_addr[s];
        if (acc) begin
            next_addr[s]++;
            if (last || (a == words_of(s) - 1)) begin
                done[s] = 1; since_done[s] = 0;
                if (!last) err[s] = 1;
            end
        end
        step();
        ld_valid[s] = 1'b0; ld_last[s] = 1'b0;
        $display("load inst=%0d word=0x%08h last=%0d accepted=%0d addr=%0d", s, w, last, acc, a);
        chk("im_we", we_o[s], acc);
        if (acc) begin
            chk("im_addr", addr_o[s], a);
            chk("im_wdata", wdata_o[s], w);
        end
        chk("load_err", err_o[s], err[s]);
        check_core(s);
        for (int g = 0; g < gap; g++) begin
            step();
            chk("im_we_idle", we_o[s], 0);
            check_core(s);
        end
    endtask

    task automatic wait_run(input int s);
        for (int k = 0; k < 16 && !(since_done[s] > hold_of(s)); k++) begin
            step();
            chk("im_we_hold", we_o[s], 0);
            check_core(s);
        end
    endtask

    task automatic run_cycle(input int s, input logic [31:0] pc, input logic ready);
        logic [31:0] ins;
        bit pop, samp;
        ins = $urandom;
        cpu_pc[s] = pc; cpu_instr[s] = ins; tr_ready[s] = ready;
        if (valid_o[s] && ready) dut_pops++;
        pop  = ready && (q.size() > 0);
        samp = !have || (pc != last_pc);
        if (pop) void'(q.pop_front());
        if (samp) begin
            have = 1; last_pc = pc;
            if (q.size() < depth_of(s)) q.push_back({pc, ins});
            else if (mdrop < dmax_of(s)) mdrop++;
        end
        step();
        $display("run inst=%0d pc=0x%08h ready=%0d sample=%0d pop=%0d count=%0d drop=%0d",
                 s, pc, ready, samp, pop, cnt_o[s], drop_o[s]);
        chk("tr_valid", valid_o[s], q.size() > 0);
        chk("tr_count", cnt_o[s], q.size());
        chk("drop_cnt", drop_o[s], mdrop);
        if (q.size() > 0) begin
            chk("tr_pc", trpc_o[s], q[0][63:32]);
            chk("tr_instr", trinstr_o[s], q[0][31:0]);
        end
        check_core(s);
    endtask

    initial begin
        logic [31:0] prog [4];
        logic [31:0] a_pcs [7];
        logic [31:0] base;
        prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020; prog[3] = 32'h0800_0003;
        a_pcs[0] = 32'h0; a_pcs[1] = 32'h4; a_pcs[2] = 32'h4; a_pcs[3] = 32'h8;
        a_pcs[4] = 32'h8; a_pcs[5] = 32'h8; a_pcs[6] = 32'hC;

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; ld_valid[s] = 1'b0; ld_data[s] = '0; ld_last[s] = 1'b0;
            cpu_pc[s] = '0; cpu_instr[s] = '0; tr_ready[s] = 1'b0;
            model_reset(s);
        end
        q.delete(); mdrop = 0; have = 0; last_pc = '0; dut_pops = 0;
        step(); step();
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) check_reset_state(s);

        // instance A: gapped load of the four-word program, then settle
        for (int i = 0; i < 4; i++) load_word(0, prog[i], i == 3, (i == 3) ? 0 : 1);
        wait_run(0);
        chk("A_load_err_clear", err_o[0], 0);

        // instance A: trace with free-running consumer
        for (int i = 0; i < 7; i++) run_cycle(0, a_pcs[i], 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(0, 32'hC, 1'b1);
        chk("A_pops", dut_pops, 4);
        chk("A_drop_zero", drop_o[0], 0);

        // instance B: five words without ld_last into a four-word memory
        for (int i = 0; i < 5; i++) load_word(1, $urandom, 1'b0, 0);
        chk("B_load_err", err_o[1], 1);
        wait_run(1);

        // instance B: fill and overflow with stalled consumer
        q.delete(); mdrop = 0; have = 0; dut_pops = 0;
        base = $urandom & 32'hFFFF_FF00;
        for (int i = 0; i < 6; i++) run_cycle(1, base + 32'(4 * i), 1'b0);
        chk("B_count_full", cnt_o[1], 4);
        chk("B_drop_two", drop_o[1], 2);
        chk("B_head_first", trpc_o[1], base);
        run_cycle(1, base + 32'd24, 1'b1);
        chk("B_count_pushpop", cnt_o[1], 4);
        for (int i = 0; i < 8; i++) run_cycle(1, base + 32'd28 + 32'(4 * i), 1'b0);
        chk("B_drop_sat", drop_o[1], 7);

        // instance B: asynchronous reset while full
        rst[1] = 1'b1;
        #1;
        model_reset(1);
        check_reset_state(1);
        step();
        rst[1] = 1'b0;
        tr_ready[1] = 1'b0;

        // instance A: reset, partial load, reset again mid-load, reload
        rst[0] = 1'b1;
        model_reset(0);
        step();
        rst[0] = 1'b0;
        load_word(0, $urandom, 1'b0, 1);
        load_word(0, $urandom, 1'b0, 1);
        rst[0] = 1'b1;
        #1;
        model_reset(0);
        check_reset_state(0);
        step();
        rst[0] = 1'b0;
        load_word(0, $urandom, 1'b0, 0);
        chk("A_reload_addr0", addr_o[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
